// File: rtl/booth_acc.sv
// Frame accumulator behind the Booth multiplier: sums NUM_TERMS signed products with
// per-step saturation and holds each finished frame sum in a one-deep valid/ready output register.
module booth_acc #(
    parameter int NUM_TERMS = 8,
    parameter int ACC_W     = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         prod_valid,
    input  logic [19:0]                  prod,
    input  logic                         acc_clear,
    input  logic                         out_ready,
    output logic                         acc_out_valid,
    output logic [ACC_W-1:0]             acc_out,
    output logic                         acc_out_sat,
    output logic                         overrun,
    output logic [$clog2(NUM_TERMS)-1:0] term_cnt
);

    localparam int CNT_W = $clog2(NUM_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);
    localparam logic signed [ACC_W:0] MAX_V = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} acc_state_e;
    typedef enum logic {EMPTY, FULL} out_state_e;

    acc_state_e        accState_q, accState_d;
    out_state_e        outState_q, outState_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  termCnt_q, termCnt_d;
    logic              frameSat_q, frameSat_d;
    logic [ACC_W-1:0]  outData_q, outData_d;
    logic              outSat_q, outSat_d;
    logic              overrun_q, overrun_d;

    logic signed [ACC_W:0] accExt, prodExt, sumRaw;
    logic [ACC_W-1:0]      sumClamp;
    logic                  stepSat;
    logic                  frameDone;

    // A cleared or idle accumulator contributes zero, so the incoming product starts a new frame.
    always_comb begin
        prodExt  = {{(ACC_W-19){prod[19]}}, prod};
        accExt   = (accState_q == ACCUM && !acc_clear) ? {acc_q[ACC_W-1], acc_q} : '0;
        sumRaw   = accExt + prodExt;
        sumClamp = sumRaw[ACC_W-1:0];
        stepSat  = 1'b0;
        if (sumRaw > MAX_V) begin
            sumClamp = MAX_V[ACC_W-1:0];
            stepSat  = 1'b1;
        end else if (sumRaw < MIN_V) begin
            sumClamp = MIN_V[ACC_W-1:0];
            stepSat  = 1'b1;
        end
    end

    always_comb begin
        accState_d = accState_q;
        acc_d      = acc_q;
        termCnt_d  = termCnt_q;
        frameSat_d = frameSat_q;
        frameDone  = 1'b0;
        if (acc_clear) begin
            accState_d = prod_valid ? ACCUM : IDLE;
            acc_d      = prod_valid ? sumClamp : '0;
            termCnt_d  = prod_valid ? CNT_W'(1) : '0;
            frameSat_d = 1'b0;
        end else if (prod_valid) begin
            case (accState_q)
                IDLE: begin
                    accState_d = ACCUM;
                    acc_d      = sumClamp;
                    termCnt_d  = CNT_W'(1);
                    frameSat_d = stepSat;
                end
                ACCUM: begin
                    if (termCnt_q == LAST_CNT) begin
                        frameDone  = 1'b1;
                        accState_d = IDLE;
                        acc_d      = '0;
                        termCnt_d  = '0;
                        frameSat_d = 1'b0;
                    end else begin
                        acc_d      = sumClamp;
                        termCnt_d  = termCnt_q + 1'b1;
                        frameSat_d = frameSat_q | stepSat;
                    end
                end
                default: accState_d = IDLE;
            endcase
        end
    end

    // The multiplier cannot stall, so a sum finishing into a held, unaccepted result is dropped.
    always_comb begin
        outState_d = outState_q;
        outData_d  = outData_q;
        outSat_d   = outSat_q;
        overrun_d  = overrun_q & ~acc_clear;
        if (frameDone) begin
            if (outState_q == EMPTY || out_ready) begin
                outState_d = FULL;
                outData_d  = sumClamp;
                outSat_d   = frameSat_q | stepSat;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (outState_q == FULL && out_ready) begin
            outState_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accState_q <= IDLE;
            outState_q <= EMPTY;
            acc_q      <= '0;
            termCnt_q  <= '0;
            frameSat_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            accState_q <= accState_d;
            outState_q <= outState_d;
            acc_q      <= acc_d;
            termCnt_q  <= termCnt_d;
            frameSat_q <= frameSat_d;
            outData_q  <= outData_d;
            outSat_q   <= outSat_d;
            overrun_q  <= overrun_d;
        end
    end

    assign acc_out_valid = (outState_q == FULL);
    assign acc_out       = outData_q;
    assign acc_out_sat   = outSat_q;
    assign overrun       = overrun_q;
    assign term_cnt      = termCnt_q;

endmodule

// File: tb/tb_booth_acc.sv
// Scoreboard bench for booth_acc: an arithmetic frame model feeds expected sums to a queue,
// and a negedge monitor compares them against whatever the output register presents.
`timescale 1ns/1ps
module tb_booth_acc;

    localparam int NT = 4;
    localparam int AW = 20;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  prod_valid = 1'b0;
    logic [19:0]           prod = '0;
    logic                  acc_clear = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  acc_out_valid;
    logic [AW-1:0]         acc_out;
    logic                  acc_out_sat;
    logic                  overrun;
    logic [$clog2(NT)-1:0] term_cnt;

    typedef struct {
        longint sum;
        bit     sat;
    } entry_t;

    entry_t expQ[$];
    entry_t pend;
    bit     pendValid = 1'b0;

    longint mAcc = 0;
    int     mCnt = 0;
    bit     mSat = 1'b0;
    bit     mOvr = 1'b0;

    int tests = 0;
    int fails = 0;

    booth_acc #(.NUM_TERMS(NT), .ACC_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prod_valid    (prod_valid),
        .prod          (prod),
        .acc_clear     (acc_clear),
        .out_ready     (out_ready),
        .acc_out_valid (acc_out_valid),
        .acc_out       (acc_out),
        .acc_out_sat   (acc_out_sat),
        .overrun       (overrun),
        .term_cnt      (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("acc_out_valid", longint'(acc_out_valid), longint'(expQ.size() > 0));
        if (acc_out_valid && expQ.size() > 0) begin
            checkVal("acc_out", $signed(acc_out), expQ[0].sum);
            checkVal("acc_out_sat", longint'(acc_out_sat), longint'(expQ[0].sat));
        end
    endtask

    // Frame rules with plain integers; the output register is modelled as a one-deep queue.
    task automatic modelStep(input bit pv, input int p, input bit clr, input bit rdy);
        longint s;
        if (clr) begin
            mOvr = 1'b0;
            mAcc = 0;
            mCnt = 0;
            mSat = 1'b0;
        end
        if (pv) begin
            s = mAcc + longint'(p);
            if (s > MAXV) begin
                s = MAXV;
                mSat = 1'b1;
            end else if (s < MINV) begin
                s = MINV;
                mSat = 1'b1;
            end
            mAcc = s;
            mCnt++;
            if (mCnt == NT) begin
                if (expQ.size() == 0 || rdy) begin
                    pend.sum  = mAcc;
                    pend.sat  = mSat;
                    pendValid = 1'b1;
                end else begin
                    mOvr = 1'b1;
                end
                mAcc = 0;
                mCnt = 0;
                mSat = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input bit pv, input int p, input bit clr, input bit rdy);
        checkVal("term_cnt", longint'(term_cnt), longint'(mCnt));
        checkVal("overrun", longint'(overrun), longint'(mOvr));
        prod_valid = pv;
        prod       = p[19:0];
        acc_clear  = clr;
        out_ready  = rdy;
        modelStep(pv, p, clr, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic asyncReset();
        #2 rst_n = 1'b0;
        #1;
        checkVal("rst acc_out_valid", longint'(acc_out_valid), 0);
        checkVal("rst acc_out", longint'(acc_out), 0);
        checkVal("rst acc_out_sat", longint'(acc_out_sat), 0);
        checkVal("rst overrun", longint'(overrun), 0);
        checkVal("rst term_cnt", longint'(term_cnt), 0);
        expQ.delete();
        pendValid  = 1'b0;
        mAcc       = 0;
        mCnt       = 0;
        mSat       = 1'b0;
        mOvr       = 1'b0;
        prod_valid = 1'b0;
        acc_clear  = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare what is held now, retire it on a handshake, then queue the sum loading next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput();
            if (acc_out_valid && out_ready && expQ.size() > 0)
                void'(expQ.pop_front());
            if (pendValid) begin
                expQ.push_back(pend);
                pendValid = 1'b0;
            end
        end
    end

    initial begin
        #2;
        checkVal("reset acc_out_valid", longint'(acc_out_valid), 0);
        checkVal("reset acc_out", longint'(acc_out), 0);
        checkVal("reset acc_out_sat", longint'(acc_out_sat), 0);
        checkVal("reset overrun", longint'(overrun), 0);
        checkVal("reset term_cnt", longint'(term_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(1, 1000, 0, 1);
        applyStimulus(1, -200, 0, 1);
        applyStimulus(1, 3, 0, 1);
        applyStimulus(1, 7, 0, 1);
        checkVal("basic sum", $signed(acc_out), 810);
        checkVal("basic valid", longint'(acc_out_valid), 1);
        checkVal("basic sat", longint'(acc_out_sat), 0);
        checkVal("basic term_cnt", longint'(term_cnt), 0);
        applyStimulus(0, 0, 0, 1);
        checkVal("basic drained", longint'(acc_out_valid), 0);

        applyStimulus(1, 262144, 0, 1);
        applyStimulus(1, 262144, 0, 1);
        applyStimulus(1, -1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkVal("sat sum", $signed(acc_out), 524286);
        checkVal("sat flag", longint'(acc_out_sat), 1);
        applyStimulus(1, -262144, 0, 1);
        applyStimulus(1, -262144, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkVal("exact min sum", $signed(acc_out), -524288);
        checkVal("exact min sat", longint'(acc_out_sat), 0);
        applyStimulus(0, 0, 0, 1);

        for (int i = 0; i < 8; i++)
            applyStimulus(1, (i < 4) ? i + 1 : 5, 0, 0);
        checkVal("backpressure hold", $signed(acc_out), 10);
        checkVal("backpressure overrun", longint'(overrun), 1);
        applyStimulus(0, 0, 0, 1);
        checkVal("backpressure drained", longint'(acc_out_valid), 0);
        applyStimulus(0, 0, 1, 0);
        checkVal("clear overrun", longint'(overrun), 0);

        for (int i = 0; i < 7; i++)
            applyStimulus(1, (i < 4) ? i + 1 : 5, 0, 0);
        checkVal("coincident before", $signed(acc_out), 10);
        applyStimulus(1, 5, 0, 1);
        checkVal("coincident valid", longint'(acc_out_valid), 1);
        checkVal("coincident sum", $signed(acc_out), 20);
        checkVal("coincident overrun", longint'(overrun), 0);
        applyStimulus(0, 0, 0, 1);

        applyStimulus(1, 100, 0, 1);
        applyStimulus(1, 100, 0, 1);
        applyStimulus(1, 5, 1, 1);
        checkVal("clear restart cnt", longint'(term_cnt), 1);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 1, 0, 1);
        checkVal("clear restart sum", $signed(acc_out), 8);
        applyStimulus(0, 0, 0, 1);

        for (int i = 0; i < 6; i++)
            applyStimulus(1, (i < 4) ? i + 1 : 9, 0, 0);
        checkVal("pre-reset valid", longint'(acc_out_valid), 1);
        asyncReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 11 + i, 0, 0);
        checkVal("post-reset sum", $signed(acc_out), 50);
        applyStimulus(0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            int p;
            bit pv;
            bit clr;
            bit rdy;
            pv  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0)
                p = int'($urandom_range(0, 1048575)) - 524288;
            else
                p = int'($urandom_range(0, 2000)) - 1000;
            applyStimulus(pv, p, clr, rdy);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_acc.md
# booth_acc

Accumulator stage directly downstream of the 3-stage Booth multiplier. It sums a fixed number of signed 20-bit products per frame into a saturating accumulator and presents each completed frame sum on a valid/ready output. The multiplier pipeline cannot be stalled, so the block absorbs one completed sum in an output register and flags any sum lost to backpressure.

## Interface

- NUM_TERMS, 8, products per frame (≥2)
- ACC_W, 24, accumulator/output width (≥20)
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- prod_valid  in  1  product present this cycle (connect to multiplier valid)
- prod  in  20  signed product
- acc_clear  in  1  synchronous abort of current partial frame
- out_ready  in  1  consumer accepts acc_out
- acc_out_valid  out  1  completed frame sum held
- acc_out  out  ACC_W  signed frame sum
- acc_out_sat  out  1  saturation occurred within the frame in acc_out
- overrun  out  1  sticky: a completed sum was dropped
- term_cnt  out  $clog2(NUM_TERMS)  terms accumulated in current frame

## Operation

- Accumulator FSM: IDLE (term_cnt=0, acc=0) and ACCUM (partial frame in progress).
  - IDLE + prod_valid → ACCUM, acc=sext(prod), term_cnt=1.
  - ACCUM + prod_valid, term_cnt<NUM_TERMS-1 → add, term_cnt+1.
  - ACCUM + prod_valid, term_cnt=NUM_TERMS-1 → frame complete: final sum offered to output register, acc=0, term_cnt=0, → IDLE.
  - prod_valid=0 → hold.
- Arithmetic: prod sign-extended to ACC_W+1; sum of acc and product computed at ACC_W+1; result clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is per step; later terms add to the clamped value. Frame sat flag set on any clamp, cleared at frame start.
- Output register (EMPTY/FULL):
  - Frame complete, register EMPTY, or FULL with out_ready=1 same cycle → load sum and sat flag, FULL.
  - Frame complete while FULL and out_ready=0 → sum discarded, overrun=1; held output unchanged.
  - out_ready=1 while FULL and no completion → EMPTY.
- acc_clear: discards partial acc, term_cnt, frame sat flag; also clears overrun. If prod_valid=1 in the same cycle, that product becomes term 1 of a new frame (acc=sext(prod), term_cnt=1). Output register unaffected. acc_clear on the completing cycle wins: no sum produced.
- Reset mid-frame or mid-handshake: all state discarded immediately.

## Timing

- Reset values: acc_out_valid=0, acc_out=0, acc_out_sat=0, overrun=0, term_cnt=0, FSM IDLE, output register EMPTY.
- Latency: acc_out_valid rises on the edge after the cycle carrying the NUM_TERMS-th product (1 cycle). acc_out/acc_out_sat registered, stable while acc_out_valid=1 and out_ready=0.
- Handshake: transfer when acc_out_valid & out_ready at posedge; acc_out_valid may stay high with new data if a completion coincides.
- Back-to-back: products accepted every cycle with no bubble, including the cycle following completion.
- No combinational path from any input to any output.

## Test plan

- NUM_TERMS=4, ACC_W=24: prod 1000, -200, 3, 7 on consecutive cycles, out_ready=1 → acc_out=810, acc_out_valid high 1 cycle after 4th, sat=0, term_cnt back to 0.
- ACC_W=20, NUM_TERMS=4: prod 262144, 262144, -1, 0 → first clamp to 524287, then 524286; acc_out=524286, acc_out_sat=1. Repeat with -262144 ×2, 0, 0 → -524288, sat=0 (exact fit, no clamp).
- Backpressure: NUM_TERMS=4, out_ready=0, two frames (sum 10 then 20) streamed continuously → acc_out holds 10, overrun=1 after second completion; raise out_ready → 10 accepted, valid drops; acc_clear → overrun=0.
- Coincident handshake: out_ready=1 on exactly the cycle a second frame completes → acc_out_valid stays 1, acc_out changes 10→20 with no gap.
- acc_clear with prod_valid=1 (prod=5) after 2 terms of 100 → new frame begins with 5; completing with 1,1,1 yields 8.
- rst_n asserted asynchronously mid-frame with acc_out_valid=1 → all outputs 0 immediately; next 4 products form a clean frame.
